// File: rtl/smash_noc_router.sv
// XY mesh router: one-entry input buffer and one-entry output register per direction, 2-cycle input-to-output latency.
// Backpressure: o_ready_D is the registered "input buffer empty"; a stalled output holds its flit until i_ready_D.
module smash_noc_router #(
  parameter int ADDR_SIZE       = 2,
  parameter int DATA_SIZE       = 32,
  parameter int NUM_ROWS        = 2,
  parameter int NUM_COLUMNS     = 2,
  parameter int ROUTER_ROW_ADDR = 0,
  parameter int ROUTER_COL_ADDR = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid_up,
  input  logic [ADDR_SIZE-1:0] i_addr_row_up,
  input  logic [ADDR_SIZE-1:0] i_addr_col_up,
  input  logic [DATA_SIZE-1:0] i_data_up,
  output logic                 o_ready_up,
  output logic                 o_valid_up,
  output logic [ADDR_SIZE-1:0] o_addr_row_up,
  output logic [ADDR_SIZE-1:0] o_addr_col_up,
  output logic [DATA_SIZE-1:0] o_data_up,
  input  logic                 i_ready_up,
  input  logic                 i_valid_down,
  input  logic [ADDR_SIZE-1:0] i_addr_row_down,
  input  logic [ADDR_SIZE-1:0] i_addr_col_down,
  input  logic [DATA_SIZE-1:0] i_data_down,
  output logic                 o_ready_down,
  output logic                 o_valid_down,
  output logic [ADDR_SIZE-1:0] o_addr_row_down,
  output logic [ADDR_SIZE-1:0] o_addr_col_down,
  output logic [DATA_SIZE-1:0] o_data_down,
  input  logic                 i_ready_down,
  input  logic                 i_valid_left,
  input  logic [ADDR_SIZE-1:0] i_addr_row_left,
  input  logic [ADDR_SIZE-1:0] i_addr_col_left,
  input  logic [DATA_SIZE-1:0] i_data_left,
  output logic                 o_ready_left,
  output logic                 o_valid_left,
  output logic [ADDR_SIZE-1:0] o_addr_row_left,
  output logic [ADDR_SIZE-1:0] o_addr_col_left,
  output logic [DATA_SIZE-1:0] o_data_left,
  input  logic                 i_ready_left,
  input  logic                 i_valid_right,
  input  logic [ADDR_SIZE-1:0] i_addr_row_right,
  input  logic [ADDR_SIZE-1:0] i_addr_col_right,
  input  logic [DATA_SIZE-1:0] i_data_right,
  output logic                 o_ready_right,
  output logic                 o_valid_right,
  output logic [ADDR_SIZE-1:0] o_addr_row_right,
  output logic [ADDR_SIZE-1:0] o_addr_col_right,
  output logic [DATA_SIZE-1:0] o_data_right,
  input  logic                 i_ready_right
);

  // Direction index order doubles as the round-robin order.
  localparam int UP    = 0;
  localparam int RIGHT = 1;
  localparam int DOWN  = 2;
  localparam int LEFT  = 3;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] row;
    logic [ADDR_SIZE-1:0] col;
    logic [DATA_SIZE-1:0] dat;
  } flit_t;

  flit_t       in_flit   [4];
  flit_t       buf_q     [4];
  flit_t       out_q     [4];
  logic [1:0]  ptr_q     [4];
  logic [2:0]  route_r   [4];
  logic [3:0]  req       [4];
  logic [1:0]  gnt_idx   [4];
  logic [3:0]  nb_vld;
  logic [3:0]  nb_rdy;
  logic [3:0]  in_vld_q;
  logic [3:0]  out_vld_q;
  logic [3:0]  gnt_vld;
  logic [3:0]  load;
  logic [3:0]  taken;
  logic [3:0]  drop;

  assign nb_vld = {i_valid_left, i_valid_down, i_valid_right, i_valid_up};
  assign nb_rdy = {i_ready_left, i_ready_down, i_ready_right, i_ready_up};

  assign in_flit[UP]    = {i_addr_row_up,    i_addr_col_up,    i_data_up};
  assign in_flit[RIGHT] = {i_addr_row_right, i_addr_col_right, i_data_right};
  assign in_flit[DOWN]  = {i_addr_row_down,  i_addr_col_down,  i_data_down};
  assign in_flit[LEFT]  = {i_addr_row_left,  i_addr_col_left,  i_data_left};

  // Returns {sink, dir}; sink covers both local delivery and out-of-mesh drops.
  function automatic logic [2:0] route_of(flit_t f);
    logic [2:0] r;
    r = {1'b1, 2'd0};
    if (32'(f.row) >= NUM_ROWS || 32'(f.col) >= NUM_COLUMNS) r = {1'b1, 2'd0};
    else if (32'(f.col) > ROUTER_COL_ADDR)                    r = {1'b0, 2'(RIGHT)};
    else if (32'(f.col) < ROUTER_COL_ADDR)                    r = {1'b0, 2'(LEFT)};
    else if (32'(f.row) > ROUTER_ROW_ADDR)                    r = {1'b0, 2'(UP)};
    else if (32'(f.row) < ROUTER_ROW_ADDR)                    r = {1'b0, 2'(DOWN)};
    return r;
  endfunction

  // Returns {found, idx}: first requester at or after ptr, wrapping.
  function automatic logic [2:0] rr_pick(logic [3:0] r, logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!pick[2] && r[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      route_r[i] = route_of(buf_q[i]);
      drop[i]    = in_vld_q[i] & route_r[i][2];
    end
  end

  always_comb begin
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++) begin
        req[o][i] = in_vld_q[i] & ~route_r[i][2] & (route_r[i][1:0] == 2'(o));
      end
    end
  end

  always_comb begin
    for (int o = 0; o < 4; o++) begin
      {gnt_vld[o], gnt_idx[o]} = rr_pick(req[o], ptr_q[o]);
      load[o] = gnt_vld[o] & (~out_vld_q[o] | nb_rdy[o]);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      taken[i] = 1'b0;
      for (int o = 0; o < 4; o++) begin
        if (load[o] && gnt_idx[o] == 2'(i)) taken[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_vld_q  <= '0;
      out_vld_q <= '0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
        out_q[i] <= '0;
        ptr_q[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (nb_vld[i] && !in_vld_q[i]) begin
          in_vld_q[i] <= 1'b1;
          buf_q[i]    <= in_flit[i];
        end else if (taken[i] || drop[i]) begin
          in_vld_q[i] <= 1'b0;
        end
      end
      for (int o = 0; o < 4; o++) begin
        if (load[o]) begin
          out_vld_q[o] <= 1'b1;
          out_q[o]     <= buf_q[gnt_idx[o]];
          ptr_q[o]     <= gnt_idx[o] + 2'd1;
        end else if (nb_rdy[o]) begin
          out_vld_q[o] <= 1'b0;
        end
      end
    end
  end

  assign o_ready_up    = ~in_vld_q[UP];
  assign o_ready_right = ~in_vld_q[RIGHT];
  assign o_ready_down  = ~in_vld_q[DOWN];
  assign o_ready_left  = ~in_vld_q[LEFT];

  assign o_valid_up    = out_vld_q[UP];
  assign o_valid_right = out_vld_q[RIGHT];
  assign o_valid_down  = out_vld_q[DOWN];
  assign o_valid_left  = out_vld_q[LEFT];

  assign {o_addr_row_up,    o_addr_col_up,    o_data_up}    = out_q[UP];
  assign {o_addr_row_right, o_addr_col_right, o_data_right} = out_q[RIGHT];
  assign {o_addr_row_down,  o_addr_col_down,  o_data_down}  = out_q[DOWN];
  assign {o_addr_row_left,  o_addr_col_left,  o_data_left}  = out_q[LEFT];

endmodule

// File: tb/tb_smash_noc_router.sv
// Directed bench for a 2x2 mesh router at (0,0); inputs driven and outputs sampled on the falling edge.
module tb_smash_noc_router;
  localparam int AW = 2;
  localparam int DW = 32;

  logic          i_clk, i_rst;
  logic          i_valid_up, i_valid_down, i_valid_left, i_valid_right;
  logic [AW-1:0] i_addr_row_up, i_addr_row_down, i_addr_row_left, i_addr_row_right;
  logic [AW-1:0] i_addr_col_up, i_addr_col_down, i_addr_col_left, i_addr_col_right;
  logic [DW-1:0] i_data_up, i_data_down, i_data_left, i_data_right;
  logic          o_ready_up, o_ready_down, o_ready_left, o_ready_right;
  logic          o_valid_up, o_valid_down, o_valid_left, o_valid_right;
  logic [AW-1:0] o_addr_row_up, o_addr_row_down, o_addr_row_left, o_addr_row_right;
  logic [AW-1:0] o_addr_col_up, o_addr_col_down, o_addr_col_left, o_addr_col_right;
  logic [DW-1:0] o_data_up, o_data_down, o_data_left, o_data_right;
  logic          i_ready_up, i_ready_down, i_ready_left, i_ready_right;

  int errors = 0;
  int checks = 0;

  smash_noc_router #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .NUM_ROWS(2), .NUM_COLUMNS(2),
    .ROUTER_ROW_ADDR(0), .ROUTER_COL_ADDR(0)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid_up(i_valid_up), .i_addr_row_up(i_addr_row_up), .i_addr_col_up(i_addr_col_up),
    .i_data_up(i_data_up), .o_ready_up(o_ready_up), .o_valid_up(o_valid_up),
    .o_addr_row_up(o_addr_row_up), .o_addr_col_up(o_addr_col_up), .o_data_up(o_data_up),
    .i_ready_up(i_ready_up),
    .i_valid_down(i_valid_down), .i_addr_row_down(i_addr_row_down), .i_addr_col_down(i_addr_col_down),
    .i_data_down(i_data_down), .o_ready_down(o_ready_down), .o_valid_down(o_valid_down),
    .o_addr_row_down(o_addr_row_down), .o_addr_col_down(o_addr_col_down), .o_data_down(o_data_down),
    .i_ready_down(i_ready_down),
    .i_valid_left(i_valid_left), .i_addr_row_left(i_addr_row_left), .i_addr_col_left(i_addr_col_left),
    .i_data_left(i_data_left), .o_ready_left(o_ready_left), .o_valid_left(o_valid_left),
    .o_addr_row_left(o_addr_row_left), .o_addr_col_left(o_addr_col_left), .o_data_left(o_data_left),
    .i_ready_left(i_ready_left),
    .i_valid_right(i_valid_right), .i_addr_row_right(i_addr_row_right), .i_addr_col_right(i_addr_col_right),
    .i_data_right(i_data_right), .o_ready_right(o_ready_right), .o_valid_right(o_valid_right),
    .o_addr_row_right(o_addr_row_right), .o_addr_col_right(o_addr_col_right), .o_data_right(o_data_right),
    .i_ready_right(i_ready_right)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++; if ({o_valid_up, o_valid_right, o_valid_down, o_valid_left} !== 4'b0000) begin errors++; $display("FAIL rst_valid: got %b want 0000", {o_valid_up, o_valid_right, o_valid_down, o_valid_left}); end
    checks++; if ({o_ready_up, o_ready_right, o_ready_down, o_ready_left} !== 4'b1111) begin errors++; $display("FAIL rst_ready: got %b want 1111", {o_ready_up, o_ready_right, o_ready_down, o_ready_left}); end
    checks++; if ({o_data_up, o_data_right, o_data_down, o_data_left} !== 128'd0) begin errors++; $display("FAIL rst_data: got nonzero want 0"); end
    checks++; if ({o_addr_row_up, o_addr_col_up, o_addr_row_right, o_addr_col_right} !== 8'd0) begin errors++; $display("FAIL rst_addr: got nonzero want 0"); end
    i_rst = 1'b1;
  endtask

  task automatic test_forward();
    @(negedge i_clk);
    i_valid_left = 1'b1; i_addr_row_left = 2'd0; i_addr_col_left = 2'd1; i_data_left = 32'hDEADBEEF;
    @(negedge i_clk);
    i_valid_left = 1'b0;
    checks++; if (o_ready_left !== 1'b0) begin errors++; $display("FAIL fwd_ready_busy: got %b want 0", o_ready_left); end
    checks++; if (o_valid_right !== 1'b0) begin errors++; $display("FAIL fwd_valid_early: got %b want 0", o_valid_right); end
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b want 1", o_valid_right); end
    checks++; if ({o_addr_row_right, o_addr_col_right} !== {2'd0, 2'd1}) begin errors++; $display("FAIL fwd_addr: got %h want 1", {o_addr_row_right, o_addr_col_right}); end
    checks++; if (o_data_right !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_data: got %h want deadbeef", o_data_right); end
    checks++; if (o_ready_left !== 1'b1) begin errors++; $display("FAIL fwd_ready_back: got %b want 1", o_ready_left); end
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b0) begin errors++; $display("FAIL fwd_one_cycle: got %b want 0", o_valid_right); end
  endtask

  task automatic test_backpressure();
    @(negedge i_clk);
    i_ready_right = 1'b0;
    i_valid_left = 1'b1; i_addr_row_left = 2'd0; i_addr_col_left = 2'd1; i_data_left = 32'hA0A00001;
    @(negedge i_clk);
    i_valid_left = 1'b0;
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b1 || o_data_right !== 32'hA0A00001) begin errors++; $display("FAIL bp_first: got %b/%h want 1/a0a00001", o_valid_right, o_data_right); end
    i_valid_left = 1'b1; i_data_left = 32'hB0B00002;
    @(negedge i_clk);
    i_valid_left = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (o_valid_right !== 1'b1 || o_data_right !== 32'hA0A00001 || {o_addr_row_right, o_addr_col_right} !== 4'b0001) begin errors++; $display("FAIL bp_hold%0d: got %b/%h want 1/a0a00001", k, o_valid_right, o_data_right); end
      checks++; if (o_ready_left !== 1'b0) begin errors++; $display("FAIL bp_buffered%0d: got %b want 0", k, o_ready_left); end
      @(negedge i_clk);
    end
    i_ready_right = 1'b1;
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b1 || o_data_right !== 32'hB0B00002) begin errors++; $display("FAIL bp_second: got %b/%h want 1/b0b00002", o_valid_right, o_data_right); end
    checks++; if (o_ready_left !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", o_ready_left); end
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", o_valid_right); end
  endtask

  task automatic test_contention();
    @(negedge i_clk);
    i_valid_down = 1'b1; i_addr_row_down = 2'd0; i_addr_col_down = 2'd1; i_data_down = 32'hD0D0D0D0;
    i_valid_left = 1'b1; i_addr_row_left = 2'd0; i_addr_col_left = 2'd1; i_data_left = 32'h1E1E1E1E;
    @(negedge i_clk);
    i_valid_down = 1'b0; i_valid_left = 1'b0;
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b1 || o_data_right !== 32'hD0D0D0D0) begin errors++; $display("FAIL cont_first: got %b/%h want 1/d0d0d0d0", o_valid_right, o_data_right); end
    checks++; if ({o_ready_down, o_ready_left} !== 2'b10) begin errors++; $display("FAIL cont_ready: got %b want 10", {o_ready_down, o_ready_left}); end
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b1 || o_data_right !== 32'h1E1E1E1E) begin errors++; $display("FAIL cont_second: got %b/%h want 1/1e1e1e1e", o_valid_right, o_data_right); end
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b0) begin errors++; $display("FAIL cont_drain: got %b want 0", o_valid_right); end
  endtask

  task automatic test_up_route();
    @(negedge i_clk);
    i_valid_left = 1'b1; i_addr_row_left = 2'd1; i_addr_col_left = 2'd0; i_data_left = 32'h12345678;
    @(negedge i_clk);
    i_valid_left = 1'b0;
    @(negedge i_clk);
    checks++; if (o_valid_up !== 1'b1 || o_data_up !== 32'h12345678) begin errors++; $display("FAIL up_flit: got %b/%h want 1/12345678", o_valid_up, o_data_up); end
    checks++; if ({o_addr_row_up, o_addr_col_up} !== 4'b0100) begin errors++; $display("FAIL up_addr: got %b want 0100", {o_addr_row_up, o_addr_col_up}); end
    checks++; if ({o_valid_right, o_valid_down, o_valid_left} !== 3'b000) begin errors++; $display("FAIL up_others: got %b want 000", {o_valid_right, o_valid_down, o_valid_left}); end
    @(negedge i_clk);
    checks++; if (o_valid_up !== 1'b0) begin errors++; $display("FAIL up_drain: got %b want 0", o_valid_up); end
  endtask

  task automatic test_absorb();
    @(negedge i_clk);
    i_valid_left  = 1'b1; i_addr_row_left  = 2'd0; i_addr_col_left  = 2'd0; i_data_left  = 32'h00000055;
    i_valid_down  = 1'b1; i_addr_row_down  = 2'd2; i_addr_col_down  = 2'd0; i_data_down  = 32'h00000066;
    i_valid_right = 1'b1; i_addr_row_right = 2'd0; i_addr_col_right = 2'd3; i_data_right = 32'h00000077;
    @(negedge i_clk);
    i_valid_left = 1'b0; i_valid_down = 1'b0; i_valid_right = 1'b0;
    checks++; if ({o_ready_right, o_ready_down, o_ready_left} !== 3'b000) begin errors++; $display("FAIL abs_busy: got %b want 000", {o_ready_right, o_ready_down, o_ready_left}); end
    @(negedge i_clk);
    checks++; if ({o_ready_up, o_ready_right, o_ready_down, o_ready_left} !== 4'b1111) begin errors++; $display("FAIL abs_ready: got %b want 1111", {o_ready_up, o_ready_right, o_ready_down, o_ready_left}); end
    checks++; if ({o_valid_up, o_valid_right, o_valid_down, o_valid_left} !== 4'b0000) begin errors++; $display("FAIL abs_nout: got %b want 0000", {o_valid_up, o_valid_right, o_valid_down, o_valid_left}); end
    @(negedge i_clk);
    checks++; if ({o_valid_up, o_valid_right, o_valid_down, o_valid_left} !== 4'b0000) begin errors++; $display("FAIL abs_nout2: got %b want 0000", {o_valid_up, o_valid_right, o_valid_down, o_valid_left}); end
  endtask

  task automatic test_reset_mid();
    @(negedge i_clk);
    i_ready_right = 1'b0;
    i_valid_up = 1'b1; i_addr_row_up = 2'd0; i_addr_col_up = 2'd1; i_data_up = 32'hC0FFEE00;
    @(negedge i_clk);
    i_valid_up = 1'b0;
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b1 || o_data_right !== 32'hC0FFEE00) begin errors++; $display("FAIL mid_loaded: got %b/%h want 1/c0ffee00", o_valid_right, o_data_right); end
    #2 i_rst = 1'b0;
    #1;
    checks++; if (o_valid_right !== 1'b0 || o_data_right !== 32'd0) begin errors++; $display("FAIL mid_async_clear: got %b/%h want 0/0", o_valid_right, o_data_right); end
    checks++; if ({o_ready_up, o_ready_right, o_ready_down, o_ready_left} !== 4'b1111) begin errors++; $display("FAIL mid_ready: got %b want 1111", {o_ready_up, o_ready_right, o_ready_down, o_ready_left}); end
    @(negedge i_clk);
    i_rst = 1'b1; i_ready_right = 1'b1;
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b0) begin errors++; $display("FAIL mid_discard: got %b want 0", o_valid_right); end
  endtask

  task automatic test_rr_after_reset();
    @(negedge i_clk);
    i_valid_up   = 1'b1; i_addr_row_up   = 2'd0; i_addr_col_up   = 2'd1; i_data_up   = 32'hAAAA0000;
    i_valid_left = 1'b1; i_addr_row_left = 2'd0; i_addr_col_left = 2'd1; i_data_left = 32'hBBBB0000;
    @(negedge i_clk);
    i_valid_up = 1'b0; i_valid_left = 1'b0;
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b1 || o_data_right !== 32'hAAAA0000) begin errors++; $display("FAIL rr_first: got %b/%h want 1/aaaa0000", o_valid_right, o_data_right); end
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b1 || o_data_right !== 32'hBBBB0000) begin errors++; $display("FAIL rr_second: got %b/%h want 1/bbbb0000", o_valid_right, o_data_right); end
    @(negedge i_clk);
    checks++; if (o_valid_right !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b want 0", o_valid_right); end
  endtask

  initial begin
    i_rst = 1'b0;
    {i_valid_up, i_valid_down, i_valid_left, i_valid_right} = '0;
    {i_addr_row_up, i_addr_row_down, i_addr_row_left, i_addr_row_right} = '0;
    {i_addr_col_up, i_addr_col_down, i_addr_col_left, i_addr_col_right} = '0;
    {i_data_up, i_data_down, i_data_left, i_data_right} = '0;
    {i_ready_up, i_ready_down, i_ready_left, i_ready_right} = 4'b1111;
    test_reset();
    test_forward();
    test_backpressure();
    test_contention();
    test_up_route();
    test_absorb();
    test_reset_mid();
    test_rr_after_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smash_noc_router.md
SMASH_NOC_ROUTER -- requirements
Module: smash_noc_router

Interface
REQ-001 Parameter ADDR_SIZE, default 2, width of the row and column address fields.
REQ-002 Parameter DATA_SIZE, default 32, payload width.
REQ-003 Parameter NUM_ROWS, default 2, mesh rows; row index increases in the "up" direction.
REQ-004 Parameter NUM_COLUMNS, default 2, mesh columns; column index increases in the "right" direction.
REQ-005 Parameter ROUTER_ROW_ADDR, default 0, row of this router.
REQ-006 Parameter ROUTER_COL_ADDR, default 0, column of this router.
REQ-007 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-008 i_rst  in  1  reset, asynchronous, active-low.
REQ-009 For each direction D in {up, down, left, right}, the router SHALL provide the following ten ports.
REQ-010 i_valid_D  in  1  an incoming flit from neighbour D is present.
REQ-011 i_addr_row_D, i_addr_col_D  in  ADDR_SIZE each  destination of the incoming flit.
REQ-012 i_data_D  in  DATA_SIZE  payload of the incoming flit.
REQ-013 o_ready_D  out  1  router can accept a flit from D.
REQ-014 o_valid_D, o_addr_row_D, o_addr_col_D, o_data_D  out  1/ADDR_SIZE/ADDR_SIZE/DATA_SIZE  outgoing flit toward D.
REQ-015 i_ready_D  in  1  neighbour D accepts the flit on o_*_D.

Function
REQ-016 Transfers: an input transfer on D occurs at an edge where i_valid_D and o_ready_D are both 1; an output transfer occurs where o_valid_D and i_ready_D are both 1.
REQ-017 Input buffering: each direction has a one-entry input buffer.
REQ-018 o_ready_D SHALL equal NOT(input buffer D full), driven from registers only, with no combinational path from any input.
REQ-019 Routing is XY, column first: if dest col > ROUTER_COL_ADDR route right, if < route left; otherwise if dest row > ROUTER_ROW_ADDR route up, if < route down.
REQ-020 Absorption: a flit whose destination equals (ROUTER_ROW_ADDR, ROUTER_COL_ADDR) SHALL be absorbed, i.e. removed from its input buffer at the next edge with no output.
REQ-021 Out-of-range destinations (row >= NUM_ROWS or col >= NUM_COLUMNS) SHALL be dropped the same way as absorbed flits.
REQ-022 Output registers: each direction has a one-entry output register holding valid, addr_row, addr_col and data, driven directly on o_*_D.
REQ-023 Switch: at each edge, every output register that is empty, or is completing an output transfer that cycle, may be loaded from one input buffer routed to it; that input buffer is cleared at the same edge.
REQ-024 Arbitration: per output, round-robin among requesting inputs in the order up, right, down, left; the pointer advances to the input after the one granted; after reset the pointer starts at up.
REQ-025 Flits are forwarded unmodified, with addr and data copied bit-exactly.
REQ-026 Latency: a flit accepted at edge N appears on o_valid_D after edge N+1, provided the output is free.
REQ-027 Throughput: each input accepts at most one flit every 2 cycles.
REQ-028 While o_valid_D=1 and i_ready_D=0, o_valid_D, o_addr_row_D, o_addr_col_D and o_data_D SHALL hold stable.
REQ-029 No flit is ever lost or duplicated except flits absorbed or dropped under REQ-020/REQ-021.

Reset
REQ-030 While i_rst=0, all buffers and output registers SHALL be cleared immediately, without waiting for a clock edge.
REQ-031 During and after reset: every o_valid_D=0, o_addr_row_D=0, o_addr_col_D=0, o_data_D=0, every o_ready_D=1, and all arbitration pointers point to up.
REQ-032 Reset asserted mid-transfer discards all in-flight flits.
REQ-033 Operation resumes at the first rising edge after i_rst returns to 1.

Verification (2x2 mesh, router at (0,0), data 32-bit)
REQ-034 Reset: pulse i_rst low -> all o_valid_*=0, all o_ready_*=1, all o_data_*=0.
REQ-035 Forward: on left, inject row0 col1 data 0xDEADBEEF with i_ready_right=1 -> o_valid_right=1 one cycle after acceptance carrying row0/col1/0xDEADBEEF for exactly one cycle; o_ready_left is 0 for one cycle.
REQ-036 Backpressure: repeat with i_ready_right=0 for 5 cycles -> output held stable; a second flit on left remains buffered with o_ready_left=0; raise i_ready_right -> both flits delivered in order.
REQ-037 Contention: down and left inputs both carry row0 col1 in the same cycle -> delivered on right in consecutive cycles, down first, then left.
REQ-038 Up route: on left, inject row1 col0 data 0x12345678 -> appears on o_*_up; all other o_valid stay 0.
REQ-039 Absorb/reset: inject row0 col0 -> no o_valid; o_ready returns to 1 after 2 cycles; assert i_rst while a flit waits in an output register -> o_valid drops immediately.
